noc_output_arbiter: RTL and testbench
=====================================

# noc_output_arbiter

Per-output-port wormhole arbiter/scheduler for the router crossbar. It shares one output link between NPORTS input FIFO buffers using round-robin arbitration and locks the grant for a whole packet (header plus payload flits). It drives the pull strobe of the granted input FIFO and forwards that FIFO's head flit downstream. Downstream buffer occupancy is tracked with a credit counter, so no flit is sent without a free slot.

## Interface
- WIDTH, `TAM_FLIT: flit width in bits.
- NPORTS, 5: number of requesting input buffers (N, S, E, W, Local).
- DEPTH, `TAM_BUFFER: downstream buffer depth; initial and maximum credit count.
- LEN_W, 8: width of the header length field, header bits [LEN_W-1:0] = payload flit count (0 allowed).
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset, synchronous, active-low.
- i_req  in  NPORTS  bit p = input FIFO p non-empty and its head packet is routed to this output.
- i_flit  in  NPORTS*WIDTH  head flits, port p at bits [p*WIDTH +: WIDTH].
- i_credit  in  1  one-cycle pulse: downstream freed one slot.
- o_pull  out  NPORTS  combinational one-hot pull to the granted FIFO; at most one bit set.
- o_flit  out  WIDTH  registered forwarded flit.
- o_valid  out  1  registered; o_flit is valid this cycle.
- o_grant  out  NPORTS  registered one-hot current grant; 0 in IDLE.
- o_credits  out  $clog2(DEPTH)+1  current credit count.

## Operation
- FSM states are IDLE, HEADER and PAYLOAD. Internal state: rr (last granted index), g (current grant), remaining (LEN_W bits), credits.
- **IDLE:** if i_req != 0, select the first requester scanning rr+1, rr+2, … mod NPORTS. Set g and o_grant to that port and go to HEADER. Otherwise stay in IDLE.
- **Transfer condition (HEADER/PAYLOAD):** xfer = i_req[g] && credits != 0. On xfer, o_pull[g]=1 in the same cycle. Next cycle: o_flit = i_flit[g] as sampled, o_valid = 1. Without xfer, o_pull = 0 and next-cycle o_valid = 0.
- **HEADER:** on xfer, load remaining = header[LEN_W-1:0].
  - If the length field is 0, the packet is complete: go to IDLE.
  - Otherwise go to PAYLOAD.
- **PAYLOAD:** on xfer, decrement remaining. When a transfer occurs with remaining == 1, the packet is complete: go to IDLE.
- **On packet completion:** rr <= g and o_grant <= 0.
- **Grant lock:** the grant is held for the whole packet, even if i_req[g] drops mid-packet (source stall). Other requesters are never granted until the tail flit is sent.
- **Credits:**
  - Decrement by 1 on xfer; increment by 1 on i_credit.
  - Both in the same cycle: credits unchanged.
  - i_credit while credits == DEPTH is ignored (saturate) and flagged by the simulation assertion.
  - When credits == 0, no pull occurs; transfer resumes the cycle after a credit returns.
- **Arithmetic:** rr wraps NPORTS-1 → 0. remaining never underflows, because it is only decremented in PAYLOAD, where it is ≥1.

## Timing
- **Reset values:** state IDLE, rr = NPORTS-1 (port 0 has first priority), g = 0, remaining = 0, credits = DEPTH. Outputs: o_grant = 0, o_valid = 0, o_flit = 0, o_pull = 0.
- **Reset mid-packet:** abandon the packet and return to all reset values on the next edge. No pull is issued during the reset cycle.
- **Latency:** request sampled in IDLE at cycle t → grant at t+1, header pull at t+1 (if credit) → header on o_flit at t+2.
- **Throughput:** 1 flit/cycle within a packet when the source and credits allow.
- **Packet gap:** IDLE lasts at least 1 cycle between packets, so the minimum gap is 1 idle o_valid cycle.
- **FIFO compatibility:** the pull is combinational, and the source FIFO advances its head at the same edge, so i_flit[g] is valid for the next pull.

## Test plan
- **Single packet:** reset; i_req=5'b00100; port 2 header len=3 then 3 payloads; credits plenty. Required: o_grant=00100 at t+1; o_valid high cycles t+2..t+5 carrying header and payloads in order; then IDLE, o_grant=0, rr=2, o_credits=DEPTH-4.
- **Round robin:** all five ports continuously request len=0 packets. Required: grant order 0,1,2,3,4,0; each header one cycle, separated by one IDLE cycle.
- **Lock under contention:** port 1 sends len=4 while port 3 raises i_req mid-packet. Required: port 3 is not granted until after port 1's 5th flit; then o_grant=01000.
- **Credit stall:** DEPTH=4, no i_credit, len=6 packet. Required: exactly 4 flits sent, o_pull=0 and o_credits=0 while stalled. Pulse i_credit once → exactly one more flit. Pulse i_credit concurrently with a transfer → o_credits unchanged.
- **Source stall:** drop i_req[g] for 3 cycles mid-payload. Required: o_valid=0 for those cycles, grant held, remaining unchanged; resume completes the packet.
- **Reset mid-packet:** assert i_rst during PAYLOAD. Required: next cycle o_grant=0, o_valid=0, o_credits=DEPTH; a subsequent request from port 0 is granted first.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin choice among input FIFOs, grant locked for a
// whole packet, flits forwarded only while the downstream buffer has free credits.
module noc_output_arbiter #(
  parameter int WIDTH  = 16,
  parameter int NPORTS = 5,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NPORTS-1:0]         i_req,
  input  logic [NPORTS*WIDTH-1:0]   i_flit,
  input  logic                      i_credit,
  output logic [NPORTS-1:0]         o_pull,
  output logic [WIDTH-1:0]          o_flit,
  output logic                      o_valid,
  output logic [NPORTS-1:0]         o_grant,
  output logic [$clog2(DEPTH):0]    o_credits,
  output logic [1:0]                o_state
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cred_q, cred_d;
  logic [WIDTH-1:0]   flit_q, flit_d;
  logic               valid_q, valid_d;
  logic [NPORTS-1:0]  grant_q, grant_d;

  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   head;
  logic               xfer;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NPORTS);
  endfunction

  // Scan from the highest offset down so the nearest requester after rr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      if (i_req[wrap_idx(int'(rr_q) + k)]) begin
        sel_vld = 1'b1;
        sel_idx = wrap_idx(int'(rr_q) + k);
      end
    end
  end

  always_comb begin
    head = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (g_q == IDX_W'(p)) head = i_flit[p*WIDTH +: WIDTH];
    end
  end

  // Handshake: o_pull is a same-cycle acknowledge of i_req[g]; the source FIFO pops
  // its head on the edge where o_pull is high, and the flit appears on o_flit after it.
  assign xfer   = i_rst && (state_q != IDLE) && i_req[g_q] && (cred_q != '0);
  assign o_pull = xfer ? (NPORTS'(1) << g_q) : '0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    flit_d  = xfer ? head : flit_q;
    valid_d = xfer;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          g_d     = sel_idx;
          grant_d = NPORTS'(1) << sel_idx;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          rem_d = head[LEN_W-1:0];
          if (head[LEN_W-1:0] == '0) begin
            state_d = IDLE;
            rr_d    = g_q;
            grant_d = '0;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            rr_d    = g_q;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A returned credit and a sent flit in the same cycle cancel out.
  always_comb begin
    cred_d = cred_q;
    if (xfer && !i_credit) begin
      cred_d = cred_q - CW'(1);
    end else if (!xfer && i_credit && (cred_q != CRED_MAX)) begin
      cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      rr_q    <= IDX_W'(NPORTS - 1);
      g_q     <= '0;
      rem_q   <= '0;
      cred_q  <= CRED_MAX;
      flit_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      cred_q  <= cred_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign o_flit    = flit_q;
  assign o_valid   = valid_q;
  assign o_grant   = grant_q;
  assign o_credits = cred_q;
  assign o_state   = state_q;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      assert (!(i_credit && !xfer && (cred_q == CRED_MAX)))
        else $error("credit returned while counter already full");
      assert ((state_q != PAYLOAD) || (rem_q != '0))
        else $error("payload state with zero flits remaining");
      assert ($onehot0(grant_q))
        else $error("grant is not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: vector table, directed corner sequences, and a
// randomized run checked against a packet-level round-robin reference model.
module tb_noc_output_arbiter;

  localparam int WIDTH  = 16;
  localparam int NPORTS = 5;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                    i_clk;
  logic                    i_rst;
  logic [NPORTS-1:0]       i_req;
  logic [NPORTS*WIDTH-1:0] i_flit;
  logic                    i_credit;
  logic [NPORTS-1:0]       o_pull;
  logic [WIDTH-1:0]        o_flit;
  logic                    o_valid;
  logic [NPORTS-1:0]       o_grant;
  logic [CW-1:0]           o_credits;
  logic [1:0]              o_state;

  noc_output_arbiter #(
    .WIDTH(WIDTH), .NPORTS(NPORTS), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_flit(i_flit),
    .i_credit(i_credit), .o_pull(o_pull), .o_flit(o_flit), .o_valid(o_valid),
    .o_grant(o_grant), .o_credits(o_credits), .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] src_q [NPORTS][$];
  logic [WIDTH-1:0] m_flits [NPORTS][$];
  int               m_len [NPORTS][$];
  int               seq [NPORTS];
  int               occ;
  int               cmode;
  logic             credit_drv;
  logic [NPORTS-1:0] stall_m, en_m, pulled;

  typedef struct {
    logic              rst;
    logic [NPORTS-1:0] req;
    logic [WIDTH-1:0]  flit2;
    logic              credit;
    logic [NPORTS-1:0] e_pull;
    logic              e_valid;
    logic [WIDTH-1:0]  e_flit;
    logic [NPORTS-1:0] e_grant;
    logic [CW-1:0]     e_cred;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic [NPORTS-1:0] req, logic [WIDTH-1:0] f2,
                              logic cr, logic [NPORTS-1:0] ep, logic ev,
                              logic [WIDTH-1:0] ef, logic [NPORTS-1:0] eg, logic [CW-1:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.flit2 = f2; v.credit = cr;
    v.e_pull = ep; v.e_valid = ev; v.e_flit = ef; v.e_grant = eg; v.e_cred = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_pkt(input int p, input int len);
    logic [WIDTH-1:0] f;
    f = {4'(p), 4'(seq[p]), 8'(len)};
    seq[p]++;
    src_q[p].push_back(f);
    m_flits[p].push_back(f);
    m_len[p].push_back(len);
    for (int i = 0; i < len; i++) begin
      f = 16'($urandom);
      src_q[p].push_back(f);
      m_flits[p].push_back(f);
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NPORTS; p++) begin
      src_q[p].delete();
      m_flits[p].delete();
      m_len[p].delete();
    end
    exp_q.delete();
  endtask

  // driver: one clock cycle of source FIFOs and downstream sink
  task automatic tick();
    logic [WIDTH-1:0] junk;
    logic ok;
    for (int p = 0; p < NPORTS; p++) begin
      i_req[p] = (src_q[p].size() != 0) && en_m[p] && !stall_m[p];
      i_flit[p*WIDTH +: WIDTH] = (src_q[p].size() != 0) ? src_q[p][0] : '0;
    end
    case (cmode)
      0:       i_credit = credit_drv;
      1:       i_credit = (occ > 0);
      default: i_credit = (occ > 0) && ($urandom_range(0, 1) == 1);
    endcase
    #1;
    pulled = o_pull;
    ok = $onehot0(pulled) && ((pulled & ~i_req) == '0);
    chk("pull_legal", {31'd0, ok}, 32'd1);
    @(posedge i_clk);
    #1;
    for (int p = 0; p < NPORTS; p++) begin
      if (pulled[p] && (src_q[p].size() != 0)) junk = src_q[p].pop_front();
    end
    if (i_credit) occ--;
    if (o_valid) occ++;
  endtask

  task automatic check_flit(input string name, input int p);
    if (m_flits[p].size() == 0) fail_now({name, " unexpected flit"});
    else chk(name, o_flit, m_flits[p].pop_front());
  endtask

  task automatic do_reset();
    clear_all();
    stall_m = '0;
    en_m = '1;
    cmode = 0;
    credit_drv = 1'b0;
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    occ = 0;
    chk("rst_grant", o_grant, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_credits", o_credits, DEPTH);
    chk("rst_flit", o_flit, 0);
  endtask

  task automatic drain(input int p, input int exp_cnt, input string name);
    int cnt;
    bit done;
    cnt = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (o_valid) begin
        check_flit({name, "_flit"}, p);
        cnt++;
      end
      if (o_state == 2'd0 && cnt > 0) done = 1;
    end
    chk({name, "_count"}, cnt, exp_cnt);
    chk({name, "_grant_released"}, o_grant, 0);
  endtask

  initial begin
    int cnt;
    int rr;
    int pick;
    int len;
    i_rst = 1'b0;
    i_req = '0;
    i_flit = '0;
    i_credit = 1'b0;
    occ = 0;
    cmode = 0;
    credit_drv = 1'b0;
    stall_m = '0;
    en_m = '1;
    for (int p = 0; p < NPORTS; p++) seq[p] = 0;

    // single packet on port 2, credit refill, then round-robin from rr=2
    vecs[0]  = mk(0, 5'b00100, 16'h2003, 0, 5'b00000, 0, 16'h0000, 5'b00000, 4);
    vecs[1]  = mk(1, 5'b00100, 16'h2003, 0, 5'b00000, 0, 16'h0000, 5'b00100, 4);
    vecs[2]  = mk(1, 5'b00100, 16'h2003, 0, 5'b00100, 1, 16'h2003, 5'b00100, 3);
    vecs[3]  = mk(1, 5'b00100, 16'h00A1, 0, 5'b00100, 1, 16'h00A1, 5'b00100, 2);
    vecs[4]  = mk(1, 5'b00100, 16'h00A2, 0, 5'b00100, 1, 16'h00A2, 5'b00100, 1);
    vecs[5]  = mk(1, 5'b00100, 16'h00A3, 0, 5'b00100, 1, 16'h00A3, 5'b00000, 0);
    vecs[6]  = mk(1, 5'b00000, 16'h0000, 0, 5'b00000, 0, 16'h0000, 5'b00000, 0);
    vecs[7]  = mk(1, 5'b00000, 16'h0000, 1, 5'b00000, 0, 16'h0000, 5'b00000, 1);
    vecs[8]  = mk(1, 5'b00000, 16'h0000, 1, 5'b00000, 0, 16'h0000, 5'b00000, 2);
    vecs[9]  = mk(1, 5'b00000, 16'h0000, 1, 5'b00000, 0, 16'h0000, 5'b00000, 3);
    vecs[10] = mk(1, 5'b00000, 16'h0000, 1, 5'b00000, 0, 16'h0000, 5'b00000, 4);
    vecs[11] = mk(1, 5'b10001, 16'h0000, 0, 5'b00000, 0, 16'h0000, 5'b10000, 4);
    vecs[12] = mk(1, 5'b10001, 16'h0000, 0, 5'b10000, 1, 16'h0000, 5'b00000, 3);
    vecs[13] = mk(1, 5'b00000, 16'h0000, 0, 5'b00000, 0, 16'h0000, 5'b00000, 3);
    vecs[14] = mk(1, 5'b00000, 16'h0000, 1, 5'b00000, 0, 16'h0000, 5'b00000, 4);

    for (int r = 0; r < NV; r++) begin
      i_rst = vecs[r].rst;
      i_req = vecs[r].req;
      i_flit = '0;
      i_flit[2*WIDTH +: WIDTH] = vecs[r].flit2;
      i_credit = vecs[r].credit;
      #1;
      chk($sformatf("vec%0d_pull", r), o_pull, vecs[r].e_pull);
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_valid", r), o_valid, vecs[r].e_valid);
      chk($sformatf("vec%0d_grant", r), o_grant, vecs[r].e_grant);
      chk($sformatf("vec%0d_credits", r), o_credits, vecs[r].e_cred);
      if (vecs[r].e_valid || !vecs[r].rst)
        chk($sformatf("vec%0d_flit", r), o_flit, vecs[r].e_flit);
    end

    // round robin over len-0 packets: 0,1,2,3,4,0 with one idle cycle between
    do_reset();
    push_pkt(0, 0);
    push_pkt(0, 0);
    for (int p = 1; p < NPORTS; p++) push_pkt(p, 0);
    for (int k = 0; k < 6; k++) begin
      credit_drv = (k > 0);
      tick();
      credit_drv = 1'b0;
      chk("rr_grant", o_grant, 1 << (k % NPORTS));
      tick();
      chk("rr_gap_grant", o_grant, 0);
      chk("rr_valid", o_valid, 1);
      check_flit("rr_flit", k % NPORTS);
    end
    credit_drv = 1'b1;
    tick();
    credit_drv = 1'b0;
    chk("rr_credits_back", o_credits, DEPTH);

    // grant lock: port 3 requests while port 1 is mid-packet
    do_reset();
    cmode = 1;
    push_pkt(1, 4);
    push_pkt(3, 0);
    en_m[3] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 5; c++) begin
      tick();
      if (o_valid) begin
        check_flit("lock_flit", 1);
        cnt++;
        en_m[3] = 1'b1;
      end
      if (cnt < 5) chk("lock_grant_held", o_grant, 5'b00010);
    end
    chk("lock_count", cnt, 5);
    chk("lock_release", o_grant, 0);
    tick();
    chk("lock_next_grant", o_grant, 5'b01000);
    tick();
    chk("lock_p3_valid", o_valid, 1);
    check_flit("lock_p3_flit", 3);

    // credit stall: len-6 packet with no credits returned
    do_reset();
    cmode = 0;
    push_pkt(0, 6);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_valid) begin
        check_flit("cstall_flit", 0);
        cnt++;
      end
    end
    chk("cstall_count", cnt, 4);
    chk("cstall_credits", o_credits, 0);
    chk("cstall_pull", pulled, 0);
    chk("cstall_grant", o_grant, 5'b00001);
    credit_drv = 1'b1;
    tick();
    credit_drv = 1'b0;
    chk("cstall_ret_valid", o_valid, 0);
    chk("cstall_ret_credits", o_credits, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_valid) begin
        check_flit("cstall_flit", 0);
        cnt++;
      end
    end
    chk("cstall_one_more", cnt, 5);
    chk("cstall_credits_again", o_credits, 0);
    credit_drv = 1'b1;
    tick();
    chk("cstall_credits_one", o_credits, 1);
    tick();
    credit_drv = 1'b0;
    chk("cstall_concurrent_credits", o_credits, 1);
    chk("cstall_concurrent_valid", o_valid, 1);
    check_flit("cstall_flit6", 0);
    tick();
    chk("cstall_tail_valid", o_valid, 1);
    check_flit("cstall_flit7", 0);
    chk("cstall_tail_credits", o_credits, 0);
    chk("cstall_tail_grant", o_grant, 0);

    // source stall mid-payload
    do_reset();
    cmode = 1;
    push_pkt(2, 5);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_valid) begin
        check_flit("sstall_flit", 2);
        cnt++;
      end
    end
    chk("sstall_pre_count", cnt, 3);
    stall_m = 5'b00100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sstall_valid", o_valid, 0);
      chk("sstall_grant", o_grant, 5'b00100);
    end
    stall_m = '0;
    drain(2, 3, "sstall_rest");

    // reset mid-packet; rr was 2 before reset, must restart at port 0
    do_reset();
    cmode = 1;
    push_pkt(2, 1);
    drain(2, 2, "rmid_pre");
    push_pkt(3, 5);
    tick();
    tick();
    tick();
    chk("rmid_in_packet_grant", o_grant, 5'b01000);
    chk("rmid_in_packet_valid", o_valid, 1);
    cmode = 0;
    credit_drv = 1'b0;
    i_rst = 1'b0;
    tick();
    chk("rmid_no_pull", pulled, 0);
    chk("rmid_grant", o_grant, 0);
    chk("rmid_valid", o_valid, 0);
    chk("rmid_credits", o_credits, DEPTH);
    clear_all();
    i_rst = 1'b1;
    occ = 0;
    push_pkt(4, 0);
    push_pkt(0, 0);
    tick();
    chk("rmid_first_grant", o_grant, 5'b00001);

    // randomized run against the packet-level reference model
    do_reset();
    cmode = 2;
    for (int p = 0; p < NPORTS; p++)
      for (int j = 0; j < 3; j++) push_pkt(p, $urandom_range(0, 6));
    rr = NPORTS - 1;
    while (1) begin
      pick = -1;
      for (int off = 1; off <= NPORTS && pick < 0; off++) begin
        if (m_len[(rr + off) % NPORTS].size() != 0) pick = (rr + off) % NPORTS;
      end
      if (pick < 0) break;
      len = m_len[pick].pop_front();
      for (int i = 0; i <= len; i++) exp_q.push_back(m_flits[pick].pop_front());
      rr = pick;
    end
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      stall_m = ($urandom_range(0, 3) == 0) ? o_grant : '0;
      tick();
      if (o_valid) begin
        if (exp_q.size() == 0) fail_now("rand_extra_flit");
        else chk("rand_flit", o_flit, exp_q.pop_front());
      end
      chk("rand_credits", o_credits, DEPTH - occ);
    end
    if (exp_q.size() != 0) fail_now("rand_timeout flits still expected");
    stall_m = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rand_no_extra", o_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
